kband_arrow_writer: RTL and testbench

- Downstream stage of the KBand affine-gap alignment subsystem. Consumes the 32-bit traceback-arrow stream produced by the KBand output stage.
- Packs four consecutive 32-bit items into one 128-bit word and buffers the words in a FIFO.
- Writes the buffered words to host memory as Avalon-MM bursts on a 128-bit / 30-bit master, matching the m0 port.
- Signals completion with a one-cycle done pulse and a level irq.

---
 rtl/kband_wr_pkg.sv | 19 +
 rtl/kband_wr_fifo.sv | 55 +++++
 rtl/kband_arrow_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_kband_arrow_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kband_wr_pkg.sv
// rtl/kband_wr_pkg.sv - shared types and constants for the KBand arrow writer
// Purpose: FSM state encoding and fixed datapath geometry.
package kband_wr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ISSUE,
        BURST,
        FLUSH,
        DONE
    } state_t;

    localparam int DATA_W       = 128;
    localparam int LANES        = 4;
    localparam int BEAT_BYTES   = 16;
    localparam int BURSTCOUNT_W = 5;

endpackage

// File: rtl/kband_wr_fifo.sv
// rtl/kband_wr_fifo.sv - synchronous show-ahead FIFO with occupancy count
// Purpose: buffers packed words between the packer and the burst master.
// Ports: clk/reset (sync, active-high); push/wdata write side;
//        pop/rdata read side (rdata valid whenever count > 0);
//        count = occupancy, full = count == DEPTH.
module kband_wr_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // simultaneous push and pop leave the count unchanged
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: emptiness is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/kband_arrow_writer.sv
// rtl/kband_arrow_writer.sv - packs 32-bit arrow items into 128-bit words and bursts them to memory
// Purpose: four items per word (lane 0 in the low bits), FIFO buffering, Avalon-MM burst writes.
// Ports: clk/reset (sync, active-high); start/base_addr/max_words job setup;
//        busy/done/irq/irq_clr/overflow/words_written status;
//        in_data/in_valid/in_ready/in_eop item stream; m0_* Avalon-MM write master.
// Optional: KBAND_ARROW_PERF_EN adds stall_cycles and burst_count counters.
module kband_arrow_writer
    import kband_wr_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 30,
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [23:0]             max_words,
    output logic                    busy,
    output logic                    done,
    output logic                    irq,
    input  logic                    irq_clr,
    output logic                    overflow,
    output logic [23:0]             words_written,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_eop,
    output logic [ADDR_W-1:0]       m0_address,
    output logic                    m0_write,
    output logic [DATA_W-1:0]       m0_writedata,
    output logic [BURSTCOUNT_W-1:0] m0_burstcount,
    output logic [15:0]             m0_byteenable,
`ifdef KBAND_ARROW_PERF_EN
    output logic [31:0]             stall_cycles,
    output logic [15:0]             burst_count,
`endif
    input  logic                    m0_waitrequest
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [23:0]             limit_q, limit_d, pushed_q, pushed_d, written_q, written_d;
    logic [1:0]              lane_q, lane_d;
    logic [DATA_W-1:0]       word_q, word_d;
    logic                    pend_q, pend_d, eop_seen_q, eop_seen_d;
    logic                    ovf_q, ovf_d, irq_q, irq_d;
    logic [BURSTCOUNT_W-1:0] len_q, len_d, beat_q, beat_d;

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic [DATA_W-1:0]       fifo_rdata;
    logic                    in_phase, dropping, accept, beat_done, last_beat, burst_go, start_ok;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^base_addr[3:0];

    kband_wr_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pend_q),
        .wdata (word_q),
        .pop   (beat_done),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign start_ok  = start && (state_q == IDLE);
    assign in_phase  = ((state_q == RUN) || (state_q == ISSUE) || (state_q == BURST)) && !eop_seen_q;
    // once the word limit is reached, items are swallowed so the producer never stalls
    assign dropping  = (pushed_q == limit_q);
    assign accept    = in_valid && in_ready;
    assign beat_done = m0_write && !m0_waitrequest;
    assign last_beat = beat_done && (beat_q == len_q - 1'b1);
    // the pending word must land before an eop-triggered burst sizes itself
    assign burst_go  = (fifo_count >= CNT_W'(BURST_MAX)) ||
                       (eop_seen_q && !pend_q && (fifo_count != '0));

    // next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (burst_go)                                        state_d = ISSUE;
                else if (eop_seen_q && !pend_q && fifo_count == '0) state_d = FLUSH;
            end
            ISSUE: state_d = BURST;
            BURST: if (last_beat) state_d = eop_seen_q ? FLUSH : RUN;
            FLUSH: begin
                if (pend_q)                 state_d = FLUSH;
                else if (fifo_count != '0)  state_d = ISSUE;
                else                        state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        busy          = (state_q != IDLE) && (state_q != DONE);
        done          = (state_q == DONE);
        m0_write      = (state_q == BURST);
        m0_byteenable = m0_write ? 16'hFFFF : 16'h0000;
        in_ready      = in_phase && (dropping || (!pend_q && !fifo_full));
    end

    // datapath
    always_comb begin
        addr_d     = addr_q;
        limit_d    = limit_q;
        pushed_d   = pushed_q;
        written_d  = written_q;
        lane_d     = lane_q;
        word_d     = word_q;
        pend_d     = 1'b0;
        eop_seen_d = eop_seen_q;
        ovf_d      = ovf_q;
        len_d      = len_q;
        beat_d     = beat_q;
        irq_d      = irq_q;

        if (start_ok) begin
            addr_d     = {base_addr[ADDR_W-1:4], 4'b0000};
            limit_d    = max_words;
            pushed_d   = '0;
            written_d  = '0;
            lane_d     = '0;
            eop_seen_d = 1'b0;
            ovf_d      = 1'b0;
        end

        if (accept) begin
            if (dropping) begin
                ovf_d = 1'b1;
            end else begin
                // a fresh word starts from zero so eop leaves unused lanes cleared
                if (lane_q == 2'd0) word_d = '0;
                word_d[lane_q*IN_W +: IN_W] = in_data;
                lane_d = lane_q + 1'b1;
                if (lane_q == 2'd3 || in_eop) begin
                    pend_d   = 1'b1;
                    lane_d   = '0;
                    pushed_d = pushed_q + 24'd1;
                end
            end
            if (in_eop) eop_seen_d = 1'b1;
        end

        if (state_q == ISSUE) begin
            len_d  = (fifo_count >= CNT_W'(BURST_MAX)) ? BURSTCOUNT_W'(BURST_MAX)
                                                       : BURSTCOUNT_W'(fifo_count);
            beat_d = '0;
        end

        if (beat_done) begin
            written_d = written_q + 24'd1;
            beat_d    = beat_q + 1'b1;
            if (last_beat) addr_d = addr_q + ADDR_W'({len_q, 4'b0000});
        end

        // a set in the done cycle outranks a coincident clear
        if (start_ok || irq_clr) irq_d = 1'b0;
        if (state_q == DONE)     irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            limit_q    <= '0;
            pushed_q   <= '0;
            written_q  <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            pend_q     <= 1'b0;
            eop_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            limit_q    <= limit_d;
            pushed_q   <= pushed_d;
            written_q  <= written_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            pend_q     <= pend_d;
            eop_seen_q <= eop_seen_d;
            ovf_q      <= ovf_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            irq_q      <= irq_d;
        end
    end

    assign irq           = irq_q;
    assign overflow      = ovf_q;
    assign words_written = written_q;
    assign m0_address    = addr_q;
    assign m0_burstcount = len_q;
    assign m0_writedata  = fifo_rdata;

`ifdef KBAND_ARROW_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] bursts_q, bursts_d;

    always_comb begin
        stall_d  = stall_q;
        bursts_d = bursts_q;
        if (start_ok) begin
            stall_d  = '0;
            bursts_d = '0;
        end else begin
            if (m0_write && m0_waitrequest && stall_q != '1) stall_d  = stall_q + 32'd1;
            if (last_beat && bursts_q != '1)                 bursts_d = bursts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bursts_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bursts_q <= bursts_d;
        end
    end

    assign stall_cycles = stall_q;
    assign burst_count  = bursts_q;
`endif

endmodule

// File: tb/tb_kband_arrow_writer.sv
// tb/tb_kband_arrow_writer.sv - randomized self-checking bench for kband_arrow_writer
module tb_kband_arrow_writer;

    logic         clk = 1'b0;
    logic         reset, start, irq_clr, in_valid, in_eop, m0_waitrequest;
    logic [29:0]  base_addr;
    logic [23:0]  max_words;
    logic [31:0]  in_data;
    logic         busy, done, irq, overflow, in_ready, m0_write;
    logic [23:0]  words_written;
    logic [29:0]  m0_address;
    logic [127:0] m0_writedata;
    logic [4:0]   m0_burstcount;
    logic [15:0]  m0_byteenable;
`ifdef KBAND_ARROW_PERF_EN
    logic [31:0]  stall_cycles;
    logic [15:0]  burst_count;
`endif

    always #5 clk = ~clk;

    kband_arrow_writer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .max_words      (max_words),
        .busy           (busy),
        .done           (done),
        .irq            (irq),
        .irq_clr        (irq_clr),
        .overflow       (overflow),
        .words_written  (words_written),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_eop         (in_eop),
        .m0_address     (m0_address),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_burstcount  (m0_burstcount),
        .m0_byteenable  (m0_byteenable),
`ifdef KBAND_ARROW_PERF_EN
        .stall_cycles   (stall_cycles),
        .burst_count    (burst_count),
`endif
        .m0_waitrequest (m0_waitrequest)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: the job's items and the words memory must end up holding
    logic [31:0]  items     [0:1023];
    logic [127:0] exp_words [0:255];
    int           exp_n;
    logic         exp_ovf;
    logic [29:0]  job_base;
    int           job_id  = 0;
    int           wr_mode = 0;

    task automatic prepare(input int n, input int maxw, input logic [29:0] base);
        int nw;
        logic [127:0] w;
        for (int i = 0; i < n; i++) items[i] = $urandom;
        nw      = (n + 3) / 4;
        exp_n   = (nw < maxw) ? nw : maxw;
        exp_ovf = (nw > maxw);
        for (int wi = 0; wi < exp_n; wi++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4*wi + k < n) w[32*k +: 32] = items[4*wi + k];
            exp_words[wi] = w;
        end
        job_base = {base[29:4], 4'b0000};
    endtask

    // bus monitor: every beat is compared against the model word for its position
    int          beat_idx = 0, n_bursts = 0, stall_seen = 0, burst_beats = 0, mon_id = 0;
    bit          in_burst = 0;
    logic [29:0] b_addr;
    logic [4:0]  b_len;
    logic [29:0] blog_addr [0:63];
    logic [4:0]  blog_len  [0:63];

    always @(negedge clk) begin
        logic [29:0] ea;
        if (mon_id != job_id) begin
            mon_id = job_id; beat_idx = 0; n_bursts = 0; stall_seen = 0; in_burst = 0; burst_beats = 0;
        end
        if (!reset && m0_write) begin
            if (!in_burst) begin
                ea = job_base + 30'(16 * beat_idx);
                chk("burst_addr", m0_address, ea);
                chk("burst_len_ok", (m0_burstcount >= 5'd1 && m0_burstcount <= 5'd16), 1'b1);
                if (n_bursts < 64) begin
                    blog_addr[n_bursts] = m0_address;
                    blog_len[n_bursts]  = m0_burstcount;
                end
                n_bursts++;
                in_burst = 1; b_addr = m0_address; b_len = m0_burstcount; burst_beats = 0;
            end else begin
                chk("addr_stable", m0_address, b_addr);
                chk("len_stable", m0_burstcount, b_len);
            end
            chk("byteenable", m0_byteenable, 16'hFFFF);
            if (m0_waitrequest) begin
                stall_seen++;
            end else begin
                if (beat_idx < exp_n) chk("beat_data", m0_writedata, exp_words[beat_idx]);
                else                  chk("extra_beat", beat_idx, exp_n);
                beat_idx++;
                burst_beats++;
                if (burst_beats == int'(b_len)) in_burst = 0;
            end
        end
    end

    // slave stall generator: 0 none, 1 random, 2 three cycles on beats 0 and 5
    initial begin
        int st_id = -1, st_beat = -1, st_n = 0;
        m0_waitrequest = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (st_id != job_id) begin st_id = job_id; st_beat = -1; st_n = 0; end
            if (wr_mode == 1) begin
                m0_waitrequest = ($urandom % 3 == 0);
            end else if (wr_mode == 2 && m0_write && (beat_idx == 0 || beat_idx == 5)) begin
                if (st_beat != beat_idx) begin st_beat = beat_idx; st_n = 0; end
                m0_waitrequest = (st_n < 3);
                if (st_n < 3) st_n++;
            end else begin
                m0_waitrequest = 1'b0;
            end
        end
    end

    task automatic feed(input int n, input bit eop_last, input int restart_at);
        int i = 0, guard = 0;
        bit acc;
        while (i < n && guard < 5000) begin
            in_valid = ($urandom % 4 != 0);
            in_data  = items[i];
            in_eop   = eop_last && (i == n - 1);
            if (guard == restart_at) begin
                start = 1'b1; base_addr = 30'h2000; max_words = 24'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0; in_eop = 1'b0; start = 1'b0;
        chk("feed_complete", i, n);
    endtask

    task automatic wait_done(input bit clr_at_done);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            if (done) begin seen = 1; if (clr_at_done) irq_clr = 1'b1; end
            cyc++;
        end
        chk("done_seen", seen, 1'b1);
        @(posedge clk); #1;
        irq_clr = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("irq_set", irq, 1'b1);
        chk("words_written", words_written, exp_n);
        chk("overflow", overflow, exp_ovf);
        chk("beats_seen", beat_idx, exp_n);
        chk("burst_closed", in_burst, 1'b0);
    endtask

    task automatic begin_job(input int n, input int maxw, input logic [29:0] base);
        prepare(n, maxw, base);
        job_id++;
        @(posedge clk); #1;
        base_addr = base; max_words = 24'(maxw); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("irq_cleared_by_start", irq, 1'b0);
        chk("ww_cleared", words_written, 24'd0);
    endtask

    task automatic run_job(input int n, input int maxw, input logic [29:0] base,
                           input int restart_at, input bit clr_at_done);
        begin_job(n, maxw, base);
        feed(n, 1'b1, restart_at);
        wait_done(clr_at_done);
    endtask

    initial begin
        bit hit;
        int cyc;
        reset = 1'b1; start = 1'b0; irq_clr = 1'b0; in_valid = 1'b0; in_eop = 1'b0;
        in_data = '0; base_addr = '0; max_words = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_ww", words_written, 24'd0);
        chk("rst_write", m0_write, 1'b0);
        chk("rst_addr", m0_address, 30'd0);
        chk("rst_bc", m0_burstcount, 5'd0);
        chk("rst_be", m0_byteenable, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);

        // 32 words: a full burst, then another full burst 256 bytes later
        run_job(128, 100, 30'h1000, -1, 0);
        chk("A_bursts", n_bursts, 2);
        chk("A_addr0", blog_addr[0], 30'h1000);
        chk("A_addr1", blog_addr[1], 30'h1100);
        chk("A_len0", blog_len[0], 5'd16);

        // partial final word, unaligned base low bits ignored
        run_job(10, 100, 30'h2347, -1, 0);
        chk("B_bursts", n_bursts, 1);
        chk("B_len", blog_len[0], 5'd3);
        chk("B_addr", blog_addr[0], 30'h2340);
        chk("B_word2_hi", exp_words[2][127:64], 64'h0);

        // stalls on beats 0 and 5
        wr_mode = 2;
        run_job(40, 100, 30'h4000, -1, 0);
        chk("C_stalls", stall_seen, 6);
`ifdef KBAND_ARROW_PERF_EN
        chk("C_perf_stall", stall_cycles, 32'd6);
        chk("C_perf_bursts", burst_count, 16'(n_bursts));
`endif
        wr_mode = 0;

        // word limit
        run_job(12, 2, 30'h5000, -1, 0);
        chk("D_ovf", overflow, 1'b1);

        // zero-length job: everything dropped, no bus traffic
        run_job(3, 0, 30'h6000, -1, 0);
        chk("Z_bursts", n_bursts, 0);

        // start while busy ignored; irq_clr coinciding with done loses
        run_job(60, 100, 30'h7000, 5, 1);
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        chk("irq_clr_alone", irq, 1'b0);

        // randomized jobs, including an address wrap near the top of the space
        wr_mode = 1;
        for (int j = 0; j < 8; j++) begin
            int n, mw;
            logic [29:0] b;
            n  = $urandom_range(1, 150);
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : 100;
            b  = (j == 3) ? 30'h3FFF_FF80 : 30'($urandom);
            run_job(n, mw, b, -1, 0);
        end
        wr_mode = 0;

        // reset in the middle of a 16-beat burst
        begin_job(64, 100, 30'h8000);
        feed(64, 1'b0, -1);
        hit = 0; cyc = 0;
        while (!hit && cyc < 2000) begin
            @(negedge clk); #1;
            if (m0_write && beat_idx == 7) hit = 1;
            cyc++;
        end
        chk("R_beat7_reached", hit, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("R_write_drop", m0_write, 1'b0);
        chk("R_busy_drop", busy, 1'b0);
        chk("R_ww_zero", words_written, 24'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_job(50, 100, 30'h9000, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
